div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle 32-bit signed/unsigned divider for the EX stage (DIV/DIVU).
- EX is the initiator: it holds start_i and stalls the pipeline. This block is the responder: it returns ready_o plus a 64-bit {remainder, quotient} result, which EX forwards toward HI/LO.
- Restoring division, one quotient bit per clock.
- Cancellation via annul_i, used when a stall/flush kills the instruction.

Parameters:
- DATA_W, 32, operand width. Fixed by RegBus; the only supported value is 32.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset; effective when rst == RstEnable (1'b1), sampled on posedge clk
- signed_div_i  in  1  1 = signed DIV, 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  DivStart (1) requests/holds a division; DivStop (0) releases the result
- annul_i  in  1  1 = abandon the current division
- result_o  out  64  [63:32] = remainder, [31:0] = quotient
- ready_o  out  1  DivResultReady (1) when result_o is valid

Behaviour:
- All outputs are registered and update only on posedge clk.
- Reset (rst = 1 at a clock edge):
  - state = DivFree, cnt = 0, result_o = 0, ready_o = 0.
  - Applies in any state, including mid-iteration; the partial result is discarded.
- States (2-bit encoding): DivFree = 00, DivByZero = 01, DivOn = 10, DivEnd = 11.
- DivFree:
  - ready_o = 0, result_o = 0.
  - Operands are latched only at the leaving edge.
  - If start_i = 1 and annul_i = 0 at edge E0:
    - opdata2_i == 0 → DivByZero.
    - Otherwise → DivOn, with cnt = 0.
    - Operands latched: if signed_div_i = 1, each negative operand is replaced by its two's complement magnitude.
    - Latched internally: the original sign bits and signed_div_i.
    - Working register (65 bits) = {32'b0, |dividend|, 1'b0}.
  - If annul_i = 1 or start_i = 0 → remain in DivFree.
- DivByZero: next edge (E1) → DivEnd with result 0 (quotient = 0, remainder = 0).
- DivOn, each edge while annul_i = 0 and cnt < 32:
  - Trial subtract: diff = working[63:32] − |divisor| (33-bit).
  - If diff is negative: working <= working << 1.
  - Otherwise: working <= {diff[31:0], working[31:0], 1'b1}.
  - cnt <= cnt + 1.
  - 32 iterations occupy edges E1..E32.
- DivOn, edge with cnt == 32 (E33):
  - Quotient = working[31:0]; remainder = working[64:33].
  - If signed and the operand signs differ: negate the quotient.
  - If signed and the dividend is negative: negate the remainder.
  - → DivEnd with result_o loaded and ready_o = 1.
- annul_i = 1 in DivOn or DivByZero: next edge → DivFree, result_o = 0, ready_o = 0, no result produced.
- DivEnd:
  - Holds result_o and ready_o = 1 while start_i = 1.
  - annul_i is ignored here.
  - start_i = 0 → next edge → DivFree, ready_o = 0, result_o = 0.
- Latency, measured from the start-sampling edge E0 to ready_o asserted:
  - Normal division: 33 edges.
  - Divide by zero: 1 edge.
- Boundary and arithmetic rules:
  - Signed 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0. No trap.
  - Unsigned divisor larger than dividend: quotient 0, remainder = dividend.
  - Operand changes after E0 are ignored.
  - start_i dropping during DivOn does not abort; only annul_i aborts. The result is produced and then released when start_i is low in DivEnd, i.e. one edge after entering DivEnd.
  - A back-to-back start requires one DivFree cycle between operations.

Decomposition:
- Add the following to the shared defines.v:
  - DivFree, DivByZero, DivOn, DivEnd state codes
  - DivResultReady / DivResultNotReady
  - DivStart / DivStop
  - DoubleRegBus (63:0)
  - Existing RegBus, ZeroWord, RstEnable
- Single module; no sub-module. The 33-bit trial subtractor stays inline.
- The EX/ctrl stall logic that drives start_i/annul_i is out of scope.

Test Plan:
1. Unsigned 100 / 7 (signed_div_i = 0), start held → ready_o = 1 exactly 33 edges after E0; result_o = {0x00000002, 0x0000000E}.
2. Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
3. Divisor 0 with dividend 0x12345678 → DivByZero, then at E1 ready_o = 1 with result_o = 0. Deassert start_i → ready_o = 0 on the next edge.
4. Start 0xFFFFFFFF / 3 unsigned; pulse annul_i at cnt = 10 → DivFree next edge, ready_o never rises. A following 9 / 3 yields quotient 3, remainder 0 at 33 edges.
5. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 5 / 9 → quotient 0, remainder 5.
6. Assert rst at cnt = 20 mid-division → next edge state DivFree, result_o = 0, ready_o = 0. Hold start_i across reset release → a new division begins on the first edge after rst drops.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divider.
// Holds the state codes, handshake levels and bus widths used by div and
// anything that drives it (EX/ctrl).
package div_pkg;

  // Divider FSM state codes (2-bit)
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic RstEnable         = 1'b1;

  localparam int REG_W        = 32;
  localparam int DOUBLE_REG_W = 64;
  localparam logic [REG_W-1:0]        ZeroWord       = '0;
  localparam logic [DOUBLE_REG_W-1:0] ZeroDoubleWord = '0;

endpackage

// File: rtl/div.sv
// Multi-cycle signed/unsigned restoring divider (DIV/DIVU), one quotient
// bit per clock.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   signed_div_i 1 = signed DIV, 0 = DIVU
//   opdata1_i    dividend (sampled only on the start edge)
//   opdata2_i    divisor  (sampled only on the start edge)
//   start_i      1 requests/holds a division, 0 releases the result
//   annul_i      1 abandons a division in progress
//   result_o     {remainder, quotient}, registered
//   ready_o      1 while result_o holds a finished result
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // {partial remainder, dividend/quotient bits, spare bit}
  logic [2*DATA_W:0]     work_q, work_d;
  logic [DATA_W-1:0]     dvsr_q, dvsr_d;
  logic                  sgn_q, sgn_d;
  logic                  neg1_q, neg1_d;
  logic                  neg2_q, neg2_d;
  logic [2*DATA_W-1:0]   result_d;
  logic                  ready_d;

  logic [DATA_W-1:0]     abs1, abs2;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quo, rem;
  logic                  go;

  assign go = (start_i == DivStart) && !annul_i;

  // Magnitudes of the incoming operands; unsigned ops pass straight through.
  assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  // 33-bit trial subtract; the top bit set means the divisor did not fit.
  assign diff = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, dvsr_q};

  // Sign fix-up applied only on the finishing edge.
  always_comb begin
    quo = work_q[DATA_W-1:0];
    rem = work_q[2*DATA_W:DATA_W+1];
    if (sgn_q && (neg1_q ^ neg2_q)) quo = ~quo + 1'b1;
    if (sgn_q && neg1_q)            rem = ~rem + 1'b1;
  end

  // State register plus all datapath/output registers
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree:   if (go) state_d = (opdata2_i == '0) ? DivByZero : DivOn;
      DivByZero: state_d = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)                state_d = DivFree;
        else if (cnt_q == CNT_LAST) state_d = DivEnd;
      end
      DivEnd:    if (start_i == DivStop) state_d = DivFree;
      default:   state_d = DivFree;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvsr_d   = dvsr_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_o;
    ready_d  = ready_o;
    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (go) begin
          cnt_d  = '0;
          dvsr_d = abs2;
          work_d = {{DATA_W{1'b0}}, abs1, 1'b0};
          sgn_d  = signed_div_i;
          neg1_d = opdata1_i[DATA_W-1];
          neg2_d = opdata2_i[DATA_W-1];
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = annul_i ? DivResultNotReady : DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q != CNT_LAST) begin
          if (diff[DATA_W]) work_d = {work_q[2*DATA_W-1:0], 1'b0};
          else              work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d = {rem, quo};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        // annul is deliberately ignored once the result exists
        if (start_i == DivStop) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase
  end

endmodule

// File: tb/tb_div.sv
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_assert = 0;
  int n_fail   = 0;

  div #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: divide magnitudes with 64-bit arithmetic, then apply signs.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic na, nb;
    longint unsigned ma, mb, q, r;
    if (b == 0) return 64'd0;
    na = s && a[31];
    nb = s && b[31];
    ma = na ? (64'h1_0000_0000 - a) : {32'd0, a};
    mb = nb ? (64'h1_0000_0000 - b) : {32'd0, b};
    q = ma / mb;
    r = ma % mb;
    if (na != nb) q = 64'h1_0000_0000 - q;
    if (na)       r = 64'h1_0000_0000 - r;
    return {r[31:0], q[31:0]};
  endfunction

  // Called right after the start edge E0. Counts edges to ready_o, checks
  // latency and result, then releases (or checks auto-release if start
  // was dropped at edge drop_at).
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [63:0] exp_res, input int drop_at);
    int  edges = 0;
    bit  got = 0;
    while (!got && edges < 40) begin
      tick();
      edges++;
      if (ready_o) got = 1;
      else if (drop_at >= 0 && edges == drop_at) start_i = 1'b0;
    end
    chk({tag, " latency"}, 64'(edges), 64'(exp_lat));
    chk({tag, " result"}, result_o, exp_res);
    if (start_i) begin
      tick();
      chk({tag, " hold"}, {result_o[62:0], ready_o}, {exp_res[62:0], 1'b1});
      start_i = 1'b0;
    end
    tick();
    chk({tag, " release"}, {result_o[62:0], ready_o}, 64'd0);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp_res, input int drop_at);
    opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1'b1;
    tick();  // E0
    // later operand changes must be ignored
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
    wait_result(tag, (b == 0) ? 1 : 33, exp_res, drop_at);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    bit          rose;

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    tick(); tick();
    chk("reset", {result_o[62:0], ready_o}, 64'd0);
    rst = 1'b0;
    tick();

    run_div("u100/7",    32'd100,        32'd7,          1'b0, {32'h2, 32'hE}, -1);
    run_div("s-7/2",     32'hFFFFFFF9,   32'h2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, -1);
    run_div("s7/-2",     32'h7,          32'hFFFFFFFE,   1'b1, {32'h1, 32'hFFFFFFFD}, -1);
    run_div("div0",      32'h12345678,   32'h0,          1'b0, 64'd0, -1);
    run_div("smin/-1",   32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h0, 32'h80000000}, -1);
    run_div("u5/9",      32'd5,          32'd9,          1'b0, {32'h5, 32'h0}, -1);
    // start dropped mid-iteration: result still arrives, then auto-releases
    run_div("dropstart", 32'd1000,       32'd33,         1'b0, {32'd10, 32'd30}, 5);

    // annul at cnt = 10
    opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    tick();
    chk("annul clear", {result_o[62:0], ready_o}, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) rose = 1;
    end
    chk("annul no ready", 64'(rose), 64'd0);
    run_div("u9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, -1);

    // reset at cnt = 20, start held across release
    opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    opdata1_i = 32'd1000; opdata2_i = 32'd10;
    tick();
    chk("midreset", {result_o[62:0], ready_o}, 64'd0);
    rst = 1'b0;
    tick();  // first edge after reset release is the new E0
    opdata1_i = $urandom; opdata2_i = $urandom;
    wait_result("post-reset", 33, {32'd0, 32'd100}, -1);

    // randomized operands against the reference model
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 4)
        0: b = b >> $urandom_range(31, 16);
        1: b = b >> $urandom_range(8, 0);
        2: a = a >> $urandom_range(31, 0);
        default: ;
      endcase
      s = 1'(i % 2);
      run_div($sformatf("rand%0d", i), a, b, s, model(a, b, s), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
